wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (ResultW path) and a long-latency unit (multiply/divide) that completes out of band.
- The pipeline has priority. Long-unit results queue in a small FIFO and drain on idle writeback cycles.
- A starvation counter forces a drain by stalling writeback for one cycle.
- Exports a pending-destination mask so the hazard unit can stall dependents.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, long-unit result FIFO entries; power of 2, >= 2.
- STARVE_MAX, 4, consecutive blocked cycles before a forced drain; >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_we  in  1  W-stage register write enable.
- pipe_rd  in  5  W-stage destination register.
- pipe_wd  in  XLEN  W-stage result (ResultW).
- lu_valid  in  1  long unit presents a result.
- lu_rd  in  5  long-unit destination register.
- lu_wd  in  XLEN  long-unit result.
- lu_ready  out  1  arbiter accepts the long-unit result this cycle.
- wb_stall  out  1  pipeline must hold the W stage and re-present it next cycle.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_wd  out  XLEN  register-file write data.
- busy_regs  out  32  bit r=1 while a write to xr is queued.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied: pointers and count = 0.
  - Starve counter = 0; busy_regs = 0.
  - lu_ready = 0, wb_stall = 0, rf_we = 0 (forced regardless of pipe_we); rf_rd = 0, rf_wd = 0.
- Pipeline write validity: pipe_act = pipe_we && pipe_rd != 0. Writes to x0 never reach the port.
- Arbitration and outputs are combinational within the cycle:
  - force = (count != 0) && (starve == STARVE_MAX).
  - pop = (count != 0) && (!pipe_act || force).
  - If pop: rf_we=1, rf_rd/rf_wd = FIFO head. wb_stall = force && pipe_act.
  - Else if pipe_act: rf_we=1, rf_rd/rf_wd = pipe_rd/pipe_wd.
  - Else: rf_we=0, rf_rd=0, rf_wd=0.
- Push side:
  - lu_ready = (count != DEPTH). There is no same-cycle bypass from a pop when the FIFO is full.
  - Accept = lu_valid && lu_ready.
  - An accepted result with lu_rd == 0 is consumed and discarded: no store, no busy bit.
  - Otherwise the entry is written at the tail and busy_regs[lu_rd] is set at the clock edge.
- Pop side: the head advances and busy_regs[head.rd] clears at the clock edge.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Bit 0 of busy_regs is always 0.
- Starve counter:
  - Cleared when count==0 or on pop.
  - Otherwise increments when count!=0 and no pop, saturating at STARVE_MAX.
  - Therefore a forced drain occurs at most every STARVE_MAX+1 cycles of continuous pipeline writes.
- Upstream contract, relied on and not checked: the hazard unit uses busy_regs to keep any instruction whose rd or rs matches a set bit from being issued. This guarantees no WAW between the FIFO and the pipeline, and no two queued entries with the same rd.
- Reset mid-operation: queued results are lost and busy_regs clears; the same reset flushes the long unit.
- Latency:
  - Pipeline write reaches the port in the same cycle when not preempted.
  - A long-unit result writes no earlier than the cycle after acceptance.

Decomposition:
- Shared package contents:
  - XLEN constant.
  - REG_ADDR_W = 5.
  - Writeback entry struct {rd[4:0], wd[XLEN-1:0]}.
  - Result-select encodings already used by the writeback mux (ALU=00, MEM=01, PC4=10).
- One natural sub-module: wb_result_fifo, a DEPTH-entry synchronous FIFO with count, full/empty flags and async active-low reset.
- Arbitration, starve counter and busy mask live in the top.

Test Plan:
- Reset with pipe_we=1, pipe_rd=5 held, rst=0 → rf_we=0, busy_regs=0, lu_ready=0; after release, rf_we=1, rf_rd=5.
- Idle pipeline (pipe_we=0); push lu_rd=7, lu_wd=0x1234 → next cycle rf_we=1, rf_rd=7, rf_wd=0x1234, busy_regs[7] high for exactly one cycle.
- pipe_we=1, pipe_rd=3 every cycle; push one lu entry (rd=9) → pipeline writes for 4 cycles. On the 5th cycle: rf_rd=9, wb_stall=1. The 6th cycle: rf_rd=3 re-presented, wb_stall=0.
- Fill FIFO with 4 entries (rd=1..4) while pipe writes continuously → lu_ready=0 at count=4; lu_valid held is not accepted; drain order is 1,2,3,4.
- Push lu_rd=0 with pipe idle → lu_ready=1, no rf write, busy_regs unchanged; pipe_we=1, pipe_rd=0 → rf_we=0.
- Simultaneous push (rd=12) and pop (rd=11) at count=2 → count stays 2, busy_regs[11] clears and busy_regs[12] sets in the same edge.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback types: data width, register address width, queued-entry layout
// and the writeback mux result-select encodings.
package wb_port_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_sel_e;
endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO holding long-unit results until the register-file write
// port is free. Caller never pushes when full or pops when empty.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  wb_entry_t     i_wdata,
  input  logic          i_pop,
  output wb_entry_t     o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W stage and a long-latency unit;
// the pipeline wins unless queued results have waited STARVE_MAX cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_wd,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_wd,
  output logic                  lu_ready,
  output logic                  wb_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wd,
  output logic [31:0]           busy_regs
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t     w_head;
  wb_entry_t     w_lu_entry;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pipe_act;
  logic          w_force;
  logic          w_pop;
  logic          w_accept;
  logic          w_push;
  logic [31:0]   w_busy_nxt;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_busy;

  assign w_lu_entry = '{rd: lu_rd, wd: lu_wd};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_lu_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pipe_act = pipe_we && (pipe_rd != '0);
  assign w_force    = !w_empty && (r_starve == SW'(STARVE_MAX));
  assign w_pop      = rst && !w_empty && (!w_pipe_act || w_force);
  assign w_accept   = lu_valid && lu_ready;
  // x0 results are acknowledged to the long unit but never stored.
  assign w_push     = w_accept && (lu_rd != '0);

  always_comb begin
    lu_ready = 1'b0;
    wb_stall = 1'b0;
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wd    = '0;
    if (rst) begin
      lu_ready = !w_full;
      if (w_pop) begin
        rf_we    = 1'b1;
        rf_rd    = w_head.rd;
        rf_wd    = w_head.wd;
        wb_stall = w_force && w_pipe_act;
      end else if (w_pipe_act) begin
        rf_we = 1'b1;
        rf_rd = pipe_rd;
        rf_wd = pipe_wd;
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop)  w_busy_nxt[w_head.rd] = 1'b0;
    if (w_push) w_busy_nxt[lu_rd]     = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
      r_busy   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (r_starve != SW'(STARVE_MAX))
        r_starve <= r_starve + SW'(1);
    end
  end

  assign busy_regs = r_busy;
endmodule
